// File: rtl/ctrl_seq_if.sv
// Fetch-to-decoder bundle: instruction in, registered control strobes out.
// Latency: none (wires only); timing is set by the attached ctrl_seq.
// Backpressure: the Stall output asks the fetch side to hold Instruction.
interface ctrl_seq_if #(
    parameter int IW = 9,
    parameter int AW = 8,
    parameter int CW = 16
);
    logic [IW-1:0] Instruction;
    logic          InstrValid;
    logic [AW-1:0] DatMemAddr;

    logic          BranchEn;
    logic          RegWrEn;
    logic          MemWrEn;
    logic          LoadInst;
    logic          TapSel;
    logic          MoveToR;
    logic          MoveFromR;
    logic          ImdLUT;
    logic [2:0]    ALU_inst;
    logic          Stall;
    logic          Ack;
    logic [CW-1:0] InstrCount;

    // Fetch unit / program counter side
    modport master (
        output Instruction, InstrValid, DatMemAddr,
        input  BranchEn, RegWrEn, MemWrEn, LoadInst, TapSel, MoveToR,
               MoveFromR, ImdLUT, ALU_inst, Stall, Ack, InstrCount
    );

    // Decoder side
    modport slave (
        input  Instruction, InstrValid, DatMemAddr,
        output BranchEn, RegWrEn, MemWrEn, LoadInst, TapSel, MoveToR,
               MoveFromR, ImdLUT, ALU_inst, Stall, Ack, InstrCount
    );
endinterface

// File: rtl/ctrl_seq.sv
// Registered instruction decoder with load-wait sequencing, sticky halt and retired count.
// Latency: 1 cycle from sampling to strobes; loads hold LoadInst for LOAD_LAT+1 cycles.
// Backpressure: Stall holds the PC during LOAD_WAIT; Instruction is not sampled then.
module ctrl_seq #(
    parameter int IW       = 9,
    parameter int AW       = 8,
    parameter int TAP_ADDR = 62,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 16
) (
    input  logic      Clk,
    input  logic      Reset,
    ctrl_seq_if.slave bus
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        HALT      = 2'd2
    } state_t;

    // A zero-latency memory returns data in the cycle right after the load is sampled,
    // so no wait state is needed at all.
    localparam bit       HAS_WAIT  = (LOAD_LAT > 0);
    localparam logic [2:0] WAIT_INIT = 3'(LOAD_LAT);
    localparam logic [AW-1:0] TAP_MATCH = AW'(TAP_ADDR);
    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    state_t        state;
    logic [2:0]    waitCnt;

    logic          branchEn;
    logic          regWrEn;
    logic          memWrEn;
    logic          loadInst;
    logic          tapSel;
    logic          moveToR;
    logic          moveFromR;
    logic          imdLut;
    logic [2:0]    aluInst;
    logic          stall;
    logic          ack;
    logic [CW-1:0] instrCount;

    logic          isHalt;
    logic          isLoad;
    logic          isStore;
    logic          isBranch;
    logic          isMoveTo;
    logic          isMoveFrom;
    logic          isImdLut;
    logic          tapHit;

    // Field decode of the instruction on the bus; halt (all ones) masks every other class.
    always_comb begin
        isHalt     = &bus.Instruction;
        isLoad     = !isHalt && (bus.Instruction[IW-1 -: 3] == 3'b000);
        isStore    = !isHalt && (bus.Instruction[IW-1 -: 3] == 3'b001);
        isBranch   = !isHalt && (bus.Instruction[IW-1 -: 3] == 3'b110);
        isMoveTo   = !isHalt && (bus.Instruction[IW-1 -: 5] == 5'b11100);
        isMoveFrom = !isHalt && (bus.Instruction[IW-1 -: 5] == 5'b11101);
        isImdLut   = !isHalt && (bus.Instruction[IW-1 -: 4] == 4'b1111);
        tapHit     = (bus.DatMemAddr == TAP_MATCH);
    end

    // Sequencer: state, wait counter, retired count and every registered strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= RUN;
            waitCnt    <= 3'd0;
            branchEn   <= 1'b0;
            regWrEn    <= 1'b0;
            memWrEn    <= 1'b0;
            loadInst   <= 1'b0;
            tapSel     <= 1'b0;
            moveToR    <= 1'b0;
            moveFromR  <= 1'b0;
            imdLut     <= 1'b0;
            aluInst    <= 3'd0;
            stall      <= 1'b0;
            ack        <= 1'b0;
            instrCount <= '0;
        end else begin
            case (state)
                RUN: begin
                    // Strobes are one-cycle pulses unless re-armed below.
                    branchEn  <= 1'b0;
                    regWrEn   <= 1'b0;
                    memWrEn   <= 1'b0;
                    loadInst  <= 1'b0;
                    tapSel    <= 1'b0;
                    moveToR   <= 1'b0;
                    moveFromR <= 1'b0;
                    imdLut    <= 1'b0;
                    aluInst   <= 3'd0;
                    stall     <= 1'b0;
                    if (bus.InstrValid) begin
                        if (instrCount != COUNT_MAX) begin
                            instrCount <= instrCount + CW'(1);
                        end
                        if (isHalt) begin
                            state <= HALT;
                            ack   <= 1'b1;
                        end else begin
                            branchEn  <= isBranch;
                            memWrEn   <= isStore;
                            moveToR   <= isMoveTo;
                            moveFromR <= isMoveFrom;
                            imdLut    <= isImdLut;
                            aluInst   <= bus.Instruction[2:0];
                            loadInst  <= isLoad;
                            tapSel    <= isLoad && tapHit;
                            if (isLoad && HAS_WAIT) begin
                                // Write-back is deferred until the memory data is ready.
                                state   <= LOAD_WAIT;
                                waitCnt <= WAIT_INIT;
                                stall   <= 1'b1;
                                regWrEn <= 1'b0;
                            end else begin
                                regWrEn <= !isStore && !isBranch;
                            end
                        end
                    end
                end

                LOAD_WAIT: begin
                    // LoadInst/TapSel keep their load values; only the counter moves.
                    waitCnt <= waitCnt - 3'd1;
                    if (waitCnt == 3'd1) begin
                        stall   <= 1'b0;
                        regWrEn <= 1'b1;
                        state   <= RUN;
                    end
                end

                HALT: begin
                    // Absorbing: only Reset leaves this state.
                    state <= HALT;
                end

                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.BranchEn   = branchEn;
    assign bus.RegWrEn    = regWrEn;
    assign bus.MemWrEn    = memWrEn;
    assign bus.LoadInst   = loadInst;
    assign bus.TapSel     = tapSel;
    assign bus.MoveToR    = moveToR;
    assign bus.MoveFromR  = moveFromR;
    assign bus.ImdLUT     = imdLut;
    assign bus.ALU_inst   = aluInst;
    assign bus.Stall      = stall;
    assign bus.Ack        = ack;
    assign bus.InstrCount = instrCount;
endmodule
